// File: rtl/ysyx_23060124_wb_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ysyx_23060124_wb_arb                                       |
// | Description : Writeback arbiter between the EXU result path and the LSU  |
// |               load-data path. One requester is granted per cycle; the    |
// |               LSU normally has priority, but an EXU that keeps losing    |
// |               is promoted after STARVE_LIMIT consecutive losses. The     |
// |               granted request is registered onto the register-file write |
// |               port and, for EXU redirects, onto a one-cycle PC pulse.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clock          in   1  single clock, rising edge                       |
// |   reset          in   1  synchronous, active-high                        |
// |   i_exu_valid    in   1  EXU writeback request                           |
// |   o_exu_ready    out  1  EXU granted this cycle (combinational)          |
// |   i_exu_rd       in   5  EXU destination register                        |
// |   i_exu_wdata    in  32  EXU result                                      |
// |   i_exu_redirect in   1  EXU request also redirects the PC               |
// |   i_exu_pc_next  in  32  redirect target                                 |
// |   i_lsu_valid    in   1  LSU writeback request                           |
// |   o_lsu_ready    out  1  LSU granted this cycle (combinational)          |
// |   i_lsu_rd       in   5  LSU destination register                        |
// |   i_lsu_wdata    in  32  load data                                       |
// |   o_rf_wen       out  1  GPR write enable (registered)                   |
// |   o_rf_waddr     out  5  GPR write address (registered)                  |
// |   o_rf_wdata     out 32  GPR write data (registered)                     |
// |   o_pc_update    out  1  one-cycle PC redirect pulse (registered)        |
// |   o_pc_next      out 32  redirect target, 0 when no pulse (registered)   |
// |   o_starve_cnt   out  3  EXU starvation count (debug)                    |
// +--------------------------------------------------------------------------+
module ysyx_23060124_wb_arb #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_exu_valid,
   output logic        o_exu_ready,
   input  logic [4:0]  i_exu_rd,
   input  logic [31:0] i_exu_wdata,
   input  logic        i_exu_redirect,
   input  logic [31:0] i_exu_pc_next,
   input  logic        i_lsu_valid,
   output logic        o_lsu_ready,
   input  logic [4:0]  i_lsu_rd,
   input  logic [31:0] i_lsu_wdata,
   output logic        o_rf_wen,
   output logic [4:0]  o_rf_waddr,
   output logic [31:0] o_rf_wdata,
   output logic        o_pc_update,
   output logic [31:0] o_pc_next,
   output logic [2:0]  o_starve_cnt
);

   localparam logic [0:0] S_LSU_PRI = 1'b0;
   localparam logic [0:0] S_EXU_PRI = 1'b1;

   localparam logic [2:0] C_CNT_MAX = 3'd7;
   localparam logic [2:0] C_LIMIT   = 3'(STARVE_LIMIT);

   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic [2:0]  r_starve_cnt;
   logic [2:0]  w_starve_cnt_nxt;

   logic        w_exu_grant;
   logic        w_lsu_grant;

   logic        w_wen;
   logic [4:0]  w_waddr;
   logic [31:0] w_wdata;
   logic        w_pc_update;
   logic [31:0] w_pc_next;

   logic        r_rf_wen;
   logic [4:0]  r_rf_waddr;
   logic [31:0] r_rf_wdata;
   logic        r_pc_update;
   logic [31:0] r_pc_next;

   // Grant: the priority side wins whenever it asks, the other side only
   // when the priority side is idle. Reset masks both so nothing handshakes.
   always_comb begin
      w_exu_grant = 1'b0;
      w_lsu_grant = 1'b0;
      if (!reset) begin
         if (r_state == S_EXU_PRI) begin
            w_exu_grant = i_exu_valid;
            w_lsu_grant = i_lsu_valid & ~i_exu_valid;
         end else begin
            w_lsu_grant = i_lsu_valid;
            w_exu_grant = i_exu_valid & ~i_lsu_valid;
         end
      end
   end

   // Starvation tracking. The count only survives while EXU keeps asking and
   // keeps losing; a single idle EXU cycle restarts it from zero.
   always_comb begin
      w_starve_cnt_nxt = 3'd0;
      if (i_exu_valid && !w_exu_grant) begin
         w_starve_cnt_nxt = (r_starve_cnt == C_CNT_MAX) ? C_CNT_MAX
                                                        : r_starve_cnt + 3'd1;
      end

      w_state_nxt = r_state;
      case (r_state)
         S_LSU_PRI: if (w_starve_cnt_nxt == C_LIMIT) w_state_nxt = S_EXU_PRI;
         S_EXU_PRI: if (w_exu_grant)                 w_state_nxt = S_LSU_PRI;
         default:                                    w_state_nxt = S_LSU_PRI;
      endcase
   end

   // Writeback selection. rd=0 still handshakes but never writes x0;
   // address/data are zeroed whenever no write is issued.
   always_comb begin
      w_wen       = 1'b0;
      w_waddr     = 5'd0;
      w_wdata     = 32'd0;
      w_pc_update = 1'b0;
      w_pc_next   = 32'd0;
      if (w_exu_grant) begin
         w_wen       = (i_exu_rd != 5'd0);
         w_waddr     = w_wen ? i_exu_rd : 5'd0;
         w_wdata     = w_wen ? i_exu_wdata : 32'd0;
         w_pc_update = i_exu_redirect;
         w_pc_next   = i_exu_redirect ? i_exu_pc_next : 32'd0;
      end else if (w_lsu_grant) begin
         w_wen       = (i_lsu_rd != 5'd0);
         w_waddr     = w_wen ? i_lsu_rd : 5'd0;
         w_wdata     = w_wen ? i_lsu_wdata : 32'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_LSU_PRI;
         r_starve_cnt <= 3'd0;
         r_rf_wen     <= 1'b0;
         r_rf_waddr   <= 5'd0;
         r_rf_wdata   <= 32'd0;
         r_pc_update  <= 1'b0;
         r_pc_next    <= 32'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_cnt_nxt;
         r_rf_wen     <= w_wen;
         r_rf_waddr   <= w_waddr;
         r_rf_wdata   <= w_wdata;
         r_pc_update  <= w_pc_update;
         r_pc_next    <= w_pc_next;
      end
   end

   assign o_exu_ready  = w_exu_grant;
   assign o_lsu_ready  = w_lsu_grant;
   assign o_rf_wen     = r_rf_wen;
   assign o_rf_waddr   = r_rf_waddr;
   assign o_rf_wdata   = r_rf_wdata;
   assign o_pc_update  = r_pc_update;
   assign o_pc_next    = r_pc_next;
   assign o_starve_cnt = r_starve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060124_wb_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ysyx_23060124_wb_arb                                    |
// | Description : Self-checking bench for the writeback arbiter. A small     |
// |               behavioural model (priority flag + loss count) predicts    |
// |               grants and registered outputs for directed and random      |
// |               stimulus.                                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ysyx_23060124_wb_arb;

   localparam int LIMIT = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        exu_valid;
   logic [4:0]  exu_rd;
   logic [31:0] exu_wdata;
   logic        exu_redirect;
   logic [31:0] exu_pc_next;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_wdata;
   logic        exu_ready;
   logic        lsu_ready;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        pc_update;
   logic [31:0] pc_next;
   logic [2:0]  starve_cnt;

   ysyx_23060124_wb_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clock          (clock),
      .reset          (reset),
      .i_exu_valid    (exu_valid),
      .o_exu_ready    (exu_ready),
      .i_exu_rd       (exu_rd),
      .i_exu_wdata    (exu_wdata),
      .i_exu_redirect (exu_redirect),
      .i_exu_pc_next  (exu_pc_next),
      .i_lsu_valid    (lsu_valid),
      .o_lsu_ready    (lsu_ready),
      .i_lsu_rd       (lsu_rd),
      .i_lsu_wdata    (lsu_wdata),
      .o_rf_wen       (rf_wen),
      .o_rf_waddr     (rf_waddr),
      .o_rf_wdata     (rf_wdata),
      .o_pc_update    (pc_update),
      .o_pc_next      (pc_next),
      .o_starve_cnt   (starve_cnt)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: who currently has priority, and how many times in a row EXU lost.
   bit          m_exu_first;
   int          m_losses;
   // Expected registered bundle {wen, waddr, wdata, pc_update, pc_next, cnt}.
   logic [73:0] m_exp;

   function automatic logic [1:0] model_grant();
      bit pri_req, oth_req;
      if (reset) return 2'b00;
      pri_req = m_exu_first ? exu_valid : lsu_valid;
      oth_req = m_exu_first ? lsu_valid : exu_valid;
      if (pri_req) return m_exu_first ? 2'b10 : 2'b01;
      if (oth_req) return m_exu_first ? 2'b01 : 2'b10;
      return 2'b00;
   endfunction

   task automatic model_advance(input logic [1:0] g);
      logic        wen;
      logic [4:0]  a;
      logic [31:0] d;
      logic        pcu;
      logic [31:0] pcn;
      if (reset) begin
         m_losses    = 0;
         m_exu_first = 0;
         m_exp       = '0;
         return;
      end
      wen = 0; a = 0; d = 0; pcu = 0; pcn = 0;
      if (g[1]) begin
         wen = (exu_rd != 0); a = exu_rd; d = exu_wdata;
         pcu = exu_redirect;  pcn = exu_redirect ? exu_pc_next : 32'd0;
      end else if (g[0]) begin
         wen = (lsu_rd != 0); a = lsu_rd; d = lsu_wdata;
      end
      if (exu_valid && !g[1]) m_losses = (m_losses >= 7) ? 7 : m_losses + 1;
      else                    m_losses = 0;
      if (g[1])                    m_exu_first = 0;
      else if (m_losses == LIMIT)  m_exu_first = 1;
      m_exp = {wen, wen ? a : 5'd0, wen ? d : 32'd0, pcu, pcn, 3'(m_losses)};
   endtask

   // Observed bundle; address/data only matter when a write is expected.
   function automatic logic [73:0] obs();
      return {rf_wen, m_exp[73] ? rf_waddr : 5'd0, m_exp[73] ? rf_wdata : 32'd0,
              pc_update, pc_next, starve_cnt};
   endfunction

   // Sample readies mid-cycle, advance the model, then clock the DUT.
   task automatic tick(output logic [1:0] rdy, output logic [1:0] g);
      #1;
      rdy = {exu_ready, lsu_ready};
      g   = model_grant();
      model_advance(g);
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      exu_valid = 0; exu_rd = 0; exu_wdata = 0; exu_redirect = 0; exu_pc_next = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
   endtask

   task automatic do_reset();
      logic [1:0] rdy, g;
      reset = 1;
      tick(rdy, g);
      reset = 0;
   endtask

   task automatic test_reset();
      logic [1:0] rdy, g;
      reset = 1;
      exu_valid = 1; exu_rd = 7; exu_wdata = 32'hA5A5_0001; exu_redirect = 1;
      exu_pc_next = 32'h8000_0040;
      lsu_valid = 1; lsu_rd = 9; lsu_wdata = 32'h0BAD_F00D;
      for (int i = 0; i < 2; i++) begin
         tick(rdy, g);
         n_checks++;
         if (rdy !== 2'b00) $display("FAIL reset_ready[%0d]: got %b want 00", i, rdy);
         else n_pass++;
         n_checks++;
         if (obs() !== 74'd0) $display("FAIL reset_outputs[%0d]: got %h want 0", i, obs());
         else n_pass++;
      end
      reset = 0;
      idle_inputs();
   endtask

   task automatic test_exu_single();
      logic [1:0] rdy, g;
      do_reset();
      exu_valid = 1; exu_rd = 5; exu_wdata = 32'h1234_5678;
      tick(rdy, g);
      n_checks++;
      if (rdy !== 2'b10) $display("FAIL exu_single_ready: got %b want 10", rdy);
      else n_pass++;
      n_checks++;
      if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234_5678})
         $display("FAIL exu_single_wb: got %b/%0d/%h want 1/5/12345678", rf_wen, rf_waddr, rf_wdata);
      else n_pass++;
      idle_inputs();
      tick(rdy, g);
      n_checks++;
      if (rf_wen !== 1'b0) $display("FAIL exu_single_idle_wen: got %b want 0", rf_wen);
      else n_pass++;
   endtask

   task automatic test_starvation();
      logic [1:0] rdy, g;
      logic [1:0] want_rdy [5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
      logic [2:0] want_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
      do_reset();
      exu_valid = 1; exu_rd = 8; exu_wdata = 32'hE0E0_0008;
      for (int i = 0; i < 5; i++) begin
         lsu_valid = 1; lsu_rd = 3; lsu_wdata = 32'h1000_0000 + i;
         tick(rdy, g);
         n_checks++;
         if (rdy !== want_rdy[i]) $display("FAIL starve_grant[%0d]: got %b want %b", i, rdy, want_rdy[i]);
         else n_pass++;
         n_checks++;
         if (starve_cnt !== want_cnt[i]) $display("FAIL starve_cnt[%0d]: got %0d want %0d", i, starve_cnt, want_cnt[i]);
         else n_pass++;
         n_checks++;
         if (obs() !== m_exp) $display("FAIL starve_wb[%0d]: got %h want %h", i, obs(), m_exp);
         else n_pass++;
         if (rdy[1]) exu_valid = 0;
      end
      idle_inputs();
   endtask

   task automatic test_redirect();
      logic [1:0] rdy, g;
      do_reset();
      exu_valid = 1; exu_rd = 1; exu_wdata = 32'h8000_0004;
      exu_redirect = 1; exu_pc_next = 32'h8000_0100;
      tick(rdy, g);
      idle_inputs();
      n_checks++;
      if ({pc_update, pc_next, rf_wen, rf_waddr} !== {1'b1, 32'h8000_0100, 1'b1, 5'd1})
         $display("FAIL redirect_pulse: got %b/%h/%b/%0d want 1/80000100/1/1", pc_update, pc_next, rf_wen, rf_waddr);
      else n_pass++;
      tick(rdy, g);
      n_checks++;
      if ({pc_update, pc_next} !== {1'b0, 32'd0})
         $display("FAIL redirect_clear: got %b/%h want 0/0", pc_update, pc_next);
      else n_pass++;
   endtask

   task automatic test_rd_zero();
      logic [1:0] rdy, g;
      do_reset();
      lsu_valid = 1; lsu_rd = 0; lsu_wdata = 32'hDEAD_BEEF;
      tick(rdy, g);
      n_checks++;
      if (rdy !== 2'b01) $display("FAIL rd0_ready: got %b want 01", rdy);
      else n_pass++;
      n_checks++;
      if (rf_wen !== 1'b0) $display("FAIL rd0_wen: got %b want 0", rf_wen);
      else n_pass++;
      // Redirect to x0 must still pulse the PC.
      idle_inputs();
      exu_valid = 1; exu_rd = 0; exu_redirect = 1; exu_pc_next = 32'h8000_2000;
      tick(rdy, g);
      n_checks++;
      if ({rf_wen, pc_update, pc_next} !== {1'b0, 1'b1, 32'h8000_2000})
         $display("FAIL rd0_redirect: got %b/%b/%h want 0/1/80002000", rf_wen, pc_update, pc_next);
      else n_pass++;
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      logic [1:0] rdy, g;
      do_reset();
      // Build up some starvation first so the reset has something to clear.
      exu_valid = 1; exu_rd = 1; exu_redirect = 1; exu_pc_next = 32'h8000_0100;
      lsu_valid = 1; lsu_rd = 4; lsu_wdata = 32'h4444_4444;
      tick(rdy, g);
      lsu_valid = 0;
      reset = 1;
      tick(rdy, g);
      reset = 0;
      n_checks++;
      if (rdy !== 2'b00) $display("FAIL reset_mid_ready: got %b want 00", rdy);
      else n_pass++;
      n_checks++;
      if ({pc_update, rf_wen, starve_cnt} !== {1'b0, 1'b0, 3'd0})
         $display("FAIL reset_mid_out: got %b/%b/%0d want 0/0/0", pc_update, rf_wen, starve_cnt);
      else n_pass++;
      idle_inputs();
   endtask

   task automatic test_toggle();
      logic [1:0] rdy, g;
      int max_cnt = 0;
      int exu_wins = 0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         exu_valid = (i % 2 == 0); exu_rd = 6; exu_wdata = 32'h0000_0066;
         lsu_valid = 1; lsu_rd = 2; lsu_wdata = 32'h2000_0000 + i;
         tick(rdy, g);
         if (rdy[1]) exu_wins++;
         if (int'(starve_cnt) > max_cnt) max_cnt = int'(starve_cnt);
         n_checks++;
         if (obs() !== m_exp) $display("FAIL toggle_wb[%0d]: got %h want %h", i, obs(), m_exp);
         else n_pass++;
      end
      n_checks++;
      if (exu_wins != 0 || max_cnt >= LIMIT)
         $display("FAIL toggle_starve: got wins=%0d max_cnt=%0d want 0/<%0d", exu_wins, max_cnt, LIMIT);
      else n_pass++;
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [1:0] rdy, g;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_wdata = 32'hB2B0_0000 + i;
         tick(rdy, g);
         n_checks++;
         if ({rdy, rf_wen, rf_waddr} !== {2'b01, 1'b1, 5'(10 + i)})
            $display("FAIL b2b[%0d]: got %b/%b/%0d want 01/1/%0d", i, rdy, rf_wen, rf_waddr, 10 + i);
         else n_pass++;
      end
      idle_inputs();
   endtask

   task automatic test_random();
      logic [1:0] rdy, g;
      bit exu_hold = 0;
      bit lsu_hold = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (!exu_hold) begin
            exu_valid    = ($urandom_range(0, 9) < 6);
            exu_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            exu_wdata    = $urandom;
            exu_redirect = ($urandom_range(0, 3) == 0);
            exu_pc_next  = $urandom;
         end
         if (!lsu_hold) begin
            lsu_valid = ($urandom_range(0, 9) < 6);
            lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lsu_wdata = $urandom;
         end
         reset = ($urandom_range(0, 49) == 0);
         tick(rdy, g);
         n_checks++;
         if (rdy !== g) $display("FAIL rand_grant[%0d]: got %b want %b", i, rdy, g);
         else n_pass++;
         n_checks++;
         if (obs() !== m_exp) $display("FAIL rand_wb[%0d]: got %h want %h", i, obs(), m_exp);
         else n_pass++;
         exu_hold = exu_valid && !g[1] && !reset;
         lsu_hold = lsu_valid && !g[0] && !reset;
         reset = 0;
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      m_exu_first = 0;
      m_losses    = 0;
      m_exp       = '0;
      @(posedge clock);
      #1;
      test_reset();
      test_exu_single();
      test_starvation();
      test_redirect();
      test_rd_zero();
      test_reset_mid();
      test_toggle();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
